// File: rtl/flit_comp_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : flitzip_arb_pkg
// Purpose  : Shared types and constants for the flit compression arbiter:
//            FSM state encoding, default sizing and a constant clog2 helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package flitzip_arb_pkg;

  // Two-state arbiter: waiting for a request, or owned by one packet.
  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  localparam int DEF_N_REQ = 8;
  localparam int DEF_ID_W  = 3;

  // Ceiling log2 for elaboration-time sizing; returns 0 for v <= 1.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/flit_comp_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : flit_comp_arbiter_if
// Purpose  : Request/grant bundle between the requesters plus compressor
//            (master side) and the arbiter (slave side).
// Signals  : req, tail, comp_ready   master -> arbiter
//            grant, grant_id,
//            grant_valid, xfer,
//            timeout_err             arbiter -> master
// Revision : 1.0 - initial release
// ============================================================================
interface flit_comp_arbiter_if #(
  parameter int N_REQ = 8,
  parameter int ID_W  = 3
);
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] tail;
  logic             comp_ready;
  logic [N_REQ-1:0] grant;
  logic [ID_W-1:0]  grant_id;
  logic             grant_valid;
  logic             xfer;
  logic             timeout_err;

  modport master (
    output req, tail, comp_ready,
    input  grant, grant_id, grant_valid, xfer, timeout_err
  );

  modport slave (
    input  req, tail, comp_ready,
    output grant, grant_id, grant_valid, xfer, timeout_err
  );
endinterface
`default_nettype wire

// File: rtl/flit_comp_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Purpose  : Combinational round-robin winner selection. Picks the lowest
//            requesting index at or above ptr; if none, the lowest requesting
//            index overall.
// Ports    : req       in   N_REQ  request vector
//            ptr       in   ID_W   round-robin start index
//            winner_oh out  N_REQ  one-hot winner (zero when no request)
//            winner_id out  ID_W   binary winner index
//            any       out  1      at least one request present
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick #(
  parameter int N_REQ = 8,
  parameter int ID_W  = 3
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] winner_oh,
  output logic [ID_W-1:0]  winner_id,
  output logic             any
);

  logic [N_REQ-1:0] mask;
  logic [N_REQ-1:0] masked;
  logic [ID_W-1:0]  masked_id;
  logic [ID_W-1:0]  raw_id;
  logic             masked_any;

  // Thermometer mask keeping indices >= ptr.
  for (genvar i = 0; i < N_REQ; i++) begin : g_mask
    assign mask[i] = (ID_W'(i) >= ptr);
  end

  assign masked     = req & mask;
  assign masked_any = |masked;
  assign any        = |req;

  // Two find-first-set encoders; scanning downward lets the lowest hit win.
  always_comb begin
    masked_id = '0;
    raw_id    = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (masked[i]) masked_id = ID_W'(i);
      if (req[i])    raw_id    = ID_W'(i);
    end
  end

  assign winner_id = masked_any ? masked_id : raw_id;

  always_comb begin
    winner_oh            = '0;
    winner_oh[winner_id] = any;
  end

endmodule
`default_nettype wire

// File: rtl/flit_comp_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : flit_comp_arbiter
// Purpose  : Round-robin, packet-atomic arbiter sharing one flit compression
//            engine among N_REQ requesters. The grant is held from head to
//            tail flit; a hold watchdog frees the engine from a stalled owner.
// Ports    : clk        in  rising-edge clock
//            rst_n      in  synchronous reset, active-low
//            bus        slave modport: req/tail/comp_ready in,
//                       grant/grant_id/grant_valid/xfer/timeout_err out
// Revision : 1.0 - initial release
// ============================================================================
module flit_comp_arbiter
  import flitzip_arb_pkg::*;
#(
  parameter int N_REQ    = DEF_N_REQ,
  parameter int ID_W     = clog2(N_REQ),
  parameter int MAX_HOLD = 64,
  parameter int CNT_W    = 7
) (
  input  logic                clk,
  input  logic                rst_n,
  flit_comp_arbiter_if.slave  bus
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
  localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(N_REQ - 1);

  arb_state_e       state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [ID_W-1:0]  grant_id_q, grant_id_d;
  logic             grant_valid_q, grant_valid_d;
  logic             timeout_q, timeout_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;

  logic [N_REQ-1:0] pick_oh;
  logic [ID_W-1:0]  pick_id;
  logic             pick_any;
  logic             owner_req;
  logic             owner_tail;
  logic             xfer;
  logic [ID_W-1:0]  next_ptr;

  rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr_pick (
    .req       (bus.req),
    .ptr       (rr_ptr_q),
    .winner_oh (pick_oh),
    .winner_id (pick_id),
    .any       (pick_any)
  );

  // grant_id is zero while idle, so xfer is masked by grant_valid.
  assign owner_req  = bus.req[grant_id_q];
  assign owner_tail = bus.tail[grant_id_q];
  assign xfer       = grant_valid_q & bus.comp_ready & owner_req;
  assign next_ptr   = (grant_id_q == LAST_ID) ? '0 : grant_id_q + ID_W'(1);

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    grant_id_d    = grant_id_q;
    grant_valid_d = grant_valid_q;
    timeout_d     = 1'b0;
    rr_ptr_d      = rr_ptr_q;
    hold_cnt_d    = hold_cnt_q;

    unique case (state_q)
      ARB_IDLE: begin
        hold_cnt_d = '0;
        if (pick_any) begin
          grant_d       = pick_oh;
          grant_id_d    = pick_id;
          grant_valid_d = 1'b1;
          state_d       = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        // Release on accepted tail, or on watchdog expiry; both advance the
        // pointer past the owner so it cannot immediately re-win.
        if ((xfer && owner_tail) || (!xfer && hold_cnt_q == HOLD_LAST)) begin
          grant_d       = '0;
          grant_id_d    = '0;
          grant_valid_d = 1'b0;
          rr_ptr_d      = next_ptr;
          hold_cnt_d    = '0;
          state_d       = ARB_IDLE;
          timeout_d     = !xfer;
        end else if (xfer) begin
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ARB_IDLE;
      grant_q       <= '0;
      grant_id_q    <= '0;
      grant_valid_q <= 1'b0;
      timeout_q     <= 1'b0;
      rr_ptr_q      <= '0;
      hold_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      grant_id_q    <= grant_id_d;
      grant_valid_q <= grant_valid_d;
      timeout_q     <= timeout_d;
      rr_ptr_q      <= rr_ptr_d;
      hold_cnt_q    <= hold_cnt_d;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_id    = grant_id_q;
  assign bus.grant_valid = grant_valid_q;
  assign bus.xfer        = xfer;
  assign bus.timeout_err = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_flit_comp_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_flit_comp_arbiter
// Purpose  : Directed, table-driven bench for flit_comp_arbiter. A second
//            instance with a short hold limit exercises the watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module tb_flit_comp_arbiter;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  flit_comp_arbiter_if #(.N_REQ(8), .ID_W(3)) bus1 ();
  flit_comp_arbiter_if #(.N_REQ(8), .ID_W(3)) bus2 ();

  flit_comp_arbiter #(.N_REQ(8), .ID_W(3), .MAX_HOLD(64), .CNT_W(7)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.slave)
  );

  flit_comp_arbiter #(.N_REQ(8), .ID_W(3), .MAX_HOLD(8), .CNT_W(4)) dut_wd (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [7:0] req;
    logic [7:0] tail;
    logic       cr;
    logic [7:0] eg;
    logic [2:0] eid;
    logic       egv;
    logic       ex;
    logic       eto;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(string n, logic [7:0] rq, logic [7:0] tl, logic cr,
                              logic [7:0] eg, logic [2:0] eid, logic egv,
                              logic ex, logic eto);
    vec_t v;
    v.name = n; v.req = rq; v.tail = tl; v.cr = cr;
    v.eg = eg; v.eid = eid; v.egv = egv; v.ex = ex; v.eto = eto;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One cycle on the main instance: drive, settle, compare, advance past edge.
  task automatic cyc1(string nm, logic r, logic [7:0] rq, logic [7:0] tl, logic cr,
                      logic [7:0] eg, logic [2:0] eid, logic egv, logic ex, logic eto);
    rst_n = r; bus1.req = rq; bus1.tail = tl; bus1.comp_ready = cr;
    #1;
    chk({nm, ".grant"},    32'(bus1.grant),       32'(eg));
    chk({nm, ".id"},       32'(bus1.grant_id),    32'(eid));
    chk({nm, ".gv"},       32'(bus1.grant_valid), 32'(egv));
    chk({nm, ".xfer"},     32'(bus1.xfer),        32'(ex));
    chk({nm, ".timeout"},  32'(bus1.timeout_err), 32'(eto));
    @(posedge clk); #1;
  endtask

  task automatic cyc2(string nm, logic [7:0] rq, logic [7:0] tl, logic cr,
                      logic [7:0] eg, logic [2:0] eid, logic egv, logic ex, logic eto);
    bus2.req = rq; bus2.tail = tl; bus2.comp_ready = cr;
    #1;
    chk({nm, ".grant"},    32'(bus2.grant),       32'(eg));
    chk({nm, ".id"},       32'(bus2.grant_id),    32'(eid));
    chk({nm, ".gv"},       32'(bus2.grant_valid), 32'(egv));
    chk({nm, ".xfer"},     32'(bus2.xfer),        32'(ex));
    chk({nm, ".timeout"},  32'(bus2.timeout_err), 32'(eto));
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus1.req = '0; bus1.tail = '0; bus1.comp_ready = 1'b0;
    bus2.req = '0; bus2.tail = '0; bus2.comp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state of both instances.
    chk("rst.grant",    32'(bus1.grant),       32'h0);
    chk("rst.id",       32'(bus1.grant_id),    32'h0);
    chk("rst.gv",       32'(bus1.grant_valid), 32'h0);
    chk("rst.xfer",     32'(bus1.xfer),        32'h0);
    chk("rst.timeout",  32'(bus1.timeout_err), 32'h0);
    chk("rst_wd.gv",    32'(bus2.grant_valid), 32'h0);
    chk("rst_wd.to",    32'(bus2.timeout_err), 32'h0);

    // Fairness: all requesting, single-flit packets, from rr_ptr=0.
    for (int g = 0; g < 9; g++) begin
      cyc1($sformatf("fair_gap%0d", g), 1'b1, 8'hFF, 8'hFF, 1'b1,
           8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
      cyc1($sformatf("fair_g%0d", g), 1'b1, 8'hFF, 8'hFF, 1'b1,
           8'(1 << (g % 8)), 3'(g % 8), 1'b1, 1'b1, 1'b0);
    end
    // rr_ptr is now 1.

    // Lone requester 2, three-flit packet.
    tbl.push_back(mk("t1_idle",  8'h04, 8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk("t1_f1",    8'h04, 8'h00, 1'b1, 8'h04, 3'd2, 1'b1, 1'b1, 1'b0));
    tbl.push_back(mk("t1_f2",    8'h04, 8'h00, 1'b1, 8'h04, 3'd2, 1'b1, 1'b1, 1'b0));
    tbl.push_back(mk("t1_f3",    8'h04, 8'h04, 1'b1, 8'h04, 3'd2, 1'b1, 1'b1, 1'b0));
    tbl.push_back(mk("t1_rel",   8'h00, 8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0));
    // rr_ptr=3: requests 1 and 3 -> 3 wins.
    tbl.push_back(mk("p3_idle",  8'h0A, 8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk("p3_g",     8'h0A, 8'h08, 1'b1, 8'h08, 3'd3, 1'b1, 1'b1, 1'b0));
    tbl.push_back(mk("p3_end",   8'h00, 8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0));
    // rr_ptr=4: owner 5 moves rr_ptr to 6.
    tbl.push_back(mk("t3_pidle", 8'h20, 8'h20, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk("t3_pg5",   8'h20, 8'h20, 1'b1, 8'h20, 3'd5, 1'b1, 1'b1, 1'b0));
    // Wrap and skip: rr_ptr=6, req 0x21 -> 0, then 5.
    tbl.push_back(mk("t3_idle",  8'h21, 8'h21, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk("t3_g0",    8'h21, 8'h21, 1'b1, 8'h01, 3'd0, 1'b1, 1'b1, 1'b0));
    tbl.push_back(mk("t3_gap",   8'h21, 8'h21, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk("t3_g5",    8'h21, 8'h21, 1'b1, 8'h20, 3'd5, 1'b1, 1'b1, 1'b0));
    tbl.push_back(mk("t3_end",   8'h00, 8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0));
    // Backpressure: owner 4 (rr_ptr=6 wraps), tail held while not ready.
    tbl.push_back(mk("t4_idle",  8'h10, 8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk("t4_f1",    8'h10, 8'h00, 1'b1, 8'h10, 3'd4, 1'b1, 1'b1, 1'b0));
    for (int k = 0; k < 10; k++)
      tbl.push_back(mk("t4_stall", 8'h12, 8'h10, 1'b0, 8'h10, 3'd4, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk("t4_tail",  8'h12, 8'h10, 1'b1, 8'h10, 3'd4, 1'b1, 1'b1, 1'b0));
    tbl.push_back(mk("t4_gap",   8'h02, 8'h02, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk("t4_g1",    8'h02, 8'h02, 1'b1, 8'h02, 3'd1, 1'b1, 1'b1, 1'b0));
    tbl.push_back(mk("t4_end",   8'h00, 8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0));

    foreach (tbl[i])
      cyc1($sformatf("%s[%0d]", tbl[i].name, i), 1'b1, tbl[i].req, tbl[i].tail,
           tbl[i].cr, tbl[i].eg, tbl[i].eid, tbl[i].egv, tbl[i].ex, tbl[i].eto);

    // Reset mid-packet: rr_ptr=2 before reset; after reset 0 must win over 7.
    cyc1("t6_idle",   1'b1, 8'h04, 8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
    cyc1("t6_rst",    1'b0, 8'h04, 8'h00, 1'b1, 8'h04, 3'd2, 1'b1, 1'b1, 1'b0);
    cyc1("t6_after",  1'b1, 8'h81, 8'h81, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
    cyc1("t6_g0",     1'b1, 8'h81, 8'h81, 1'b1, 8'h01, 3'd0, 1'b1, 1'b1, 1'b0);
    cyc1("t6_gap",    1'b1, 8'h80, 8'h80, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
    cyc1("t6_g7",     1'b1, 8'h80, 8'h80, 1'b1, 8'h80, 3'd7, 1'b1, 1'b1, 1'b0);
    cyc1("t6_end",    1'b1, 8'h00, 8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);

    // Watchdog on the MAX_HOLD=8 instance: owner 3 stalls without tail.
    cyc2("t5_idle",   8'h08, 8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
    cyc2("t5_f1",     8'h08, 8'h00, 1'b1, 8'h08, 3'd3, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 8; k++)
      cyc2($sformatf("t5_hold%0d", k), 8'h00, 8'h00, 1'b1, 8'h08, 3'd3, 1'b1, 1'b0, 1'b0);
    cyc2("t5_to",     8'h19, 8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, 1'b1);
    cyc2("t5_next",   8'h19, 8'h00, 1'b1, 8'h10, 3'd4, 1'b1, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
